// File: rtl/random_read_main.sv
// Read-side microbenchmark core: sums len words from a 1-port memory, reports cycles and sum.
// Optional RANDOM_READ_CHECK_EN adds a per-word pattern checker and a third error-count token.
module random_read_main #(
   parameter int unsigned SIMD_WIDTH     = 1,
   parameter int unsigned LOG_SIMD_WIDTH = 0,
   parameter int unsigned W_D            = 32,
   parameter int unsigned W_A            = 12,
   parameter int unsigned W_COMM_D       = 32
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   output logic [W_A-1:0]            mem_addr_o,
   input  logic [W_D*SIMD_WIDTH-1:0] mem_q_i,
   input  logic [W_COMM_D-1:0]       comm_q_i,
   input  logic                      comm_empty_i,
   output logic                      comm_deq_o,
   output logic [W_COMM_D-1:0]       comm_d_o,
   output logic                      comm_enq_o,
   input  logic                      comm_full_i
);

   localparam int unsigned WLen = W_A + 1;
   localparam int unsigned Lanes = 1 << LOG_SIMD_WIDTH;
   localparam logic [WLen-1:0] MaxLen = {1'b1, {W_A{1'b0}}};

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StWait   = 3'd1;
   localparam logic [2:0] StRun    = 3'd2;
   localparam logic [2:0] StDrain  = 3'd3;
   localparam logic [2:0] StRptCyc = 3'd4;
   localparam logic [2:0] StRptSum = 3'd5;
`ifdef RANDOM_READ_CHECK_EN
   localparam logic [2:0] StRptErr = 3'd6;
`endif

   logic [2:0]          state_q, state_d;
   logic [W_A-1:0]      addr_q, addr_d;
   logic [WLen-1:0]     len_q, len_d;
   logic [W_COMM_D-1:0] sum_q, sum_d;
   logic [W_COMM_D-1:0] cnt_q, cnt_d;
   logic [W_COMM_D-1:0] comm_d_q, comm_d_d;
   logic                deq_q, deq_d;
   logic                enq_q, enq_d;
   logic                vld_q, vld_d;
   logic [W_COMM_D-1:0] lane_sum;

   always_comb begin
      lane_sum = '0;
      for (int l = 0; l < Lanes; l++) begin
         lane_sum = lane_sum + W_COMM_D'(mem_q_i[l*W_D +: W_D]);
      end
   end

`ifdef RANDOM_READ_CHECK_EN
   logic [W_A-1:0]      rd_addr_q;
   logic [W_COMM_D-1:0] err_q, err_d;
   logic                word_bad;

   // rd_addr_q tracks the address whose data is on mem_q_i this cycle.
   always_comb begin
      word_bad = 1'b0;
      for (int l = 0; l < Lanes; l++) begin
         if (mem_q_i[l*W_D +: W_D] !=
             W_D'((32'(rd_addr_q) << LOG_SIMD_WIDTH) + 32'(l))) begin
            word_bad = 1'b1;
         end
      end
   end
`endif

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      len_d    = len_q;
      sum_d    = sum_q;
      cnt_d    = cnt_q;
      comm_d_d = comm_d_q;
      deq_d    = 1'b0;
      enq_d    = 1'b0;
      vld_d    = (state_q == StRun);
`ifdef RANDOM_READ_CHECK_EN
      err_d    = err_q;
      if (vld_q && word_bad && (err_q != '1)) err_d = err_q + W_COMM_D'(1);
`endif
      if (vld_q) sum_d = sum_q + lane_sum;
      case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (!comm_empty_i) begin
               deq_d   = 1'b1;
               len_d   = (comm_q_i > W_COMM_D'(MaxLen)) ? MaxLen : comm_q_i[WLen-1:0];
               sum_d   = '0;
               addr_d  = '0;
               state_d = StWait;
`ifdef RANDOM_READ_CHECK_EN
               err_d   = '0;
`endif
            end
         end
         StWait: begin
            cnt_d   = cnt_q + W_COMM_D'(1);
            state_d = (len_q == '0) ? StRptCyc : StRun;
         end
         StRun: begin
            cnt_d = cnt_q + W_COMM_D'(1);
            if ({1'b0, addr_q} == len_q - WLen'(1)) state_d = StDrain;
            else addr_d = addr_q + W_A'(1);
         end
         StDrain: state_d = StRptCyc;
         StRptCyc: begin
            // The +1 accounts for the report cycle itself.
            if (!comm_full_i) begin
               enq_d    = 1'b1;
               comm_d_d = cnt_q + W_COMM_D'(1);
               state_d  = StRptSum;
            end else begin
               cnt_d = cnt_q + W_COMM_D'(1);
            end
         end
         StRptSum: begin
            if (!comm_full_i) begin
               enq_d    = 1'b1;
               comm_d_d = sum_q;
`ifdef RANDOM_READ_CHECK_EN
               state_d  = StRptErr;
`else
               state_d  = StIdle;
`endif
            end
         end
`ifdef RANDOM_READ_CHECK_EN
         StRptErr: begin
            if (!comm_full_i) begin
               enq_d    = 1'b1;
               comm_d_d = err_q;
               state_d  = StIdle;
            end
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         addr_q   <= '0;
         len_q    <= '0;
         sum_q    <= '0;
         cnt_q    <= '0;
         comm_d_q <= '0;
         deq_q    <= 1'b0;
         enq_q    <= 1'b0;
         vld_q    <= 1'b0;
`ifdef RANDOM_READ_CHECK_EN
         err_q     <= '0;
         rd_addr_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         len_q    <= len_d;
         sum_q    <= sum_d;
         cnt_q    <= cnt_d;
         comm_d_q <= comm_d_d;
         deq_q    <= deq_d;
         enq_q    <= enq_d;
         vld_q    <= vld_d;
`ifdef RANDOM_READ_CHECK_EN
         err_q     <= err_d;
         rd_addr_q <= addr_q;
`endif
      end
   end

   assign mem_addr_o = addr_q;
   assign comm_deq_o = deq_q;
   assign comm_enq_o = enq_q;
   assign comm_d_o   = comm_d_q;

endmodule
